// File: rtl/frame_gen_pkg.sv
// Shared types for the frame generator sequencer.
// Block-type tags, FSM state encoding and tag width.
package frame_gen_pkg;

  localparam int NB_TYPE = 3;

  localparam logic [NB_TYPE-1:0] BT_IDLE  = 3'd0;
  localparam logic [NB_TYPE-1:0] BT_START = 3'd1;
  localparam logic [NB_TYPE-1:0] BT_DATA  = 3'd2;
  localparam logic [NB_TYPE-1:0] BT_TERM  = 3'd3;
  localparam logic [NB_TYPE-1:0] BT_ERROR = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_TERM  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_gen_len_counter.sv
// Loadable up-counter with terminal-count flag.
// o_tc is high once the count reaches limit-1; the count then saturates.
module frame_gen_len_counter #(
  parameter int            NB      = 16,
  parameter logic [NB-1:0] RST_LIM = '0
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [NB-1:0] i_limit,
  input  logic          i_inc,
  output logic          o_tc
);

  logic [NB-1:0] cnt;
  logic [NB-1:0] lim;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt <= '0;
      lim <= RST_LIM;
    end else if (i_load) begin
      cnt <= '0;
      lim <= i_limit;
    end else if (i_inc && !o_tc) begin
      cnt <= cnt + NB'(1);
    end
  end

  assign o_tc = (cnt == lim - NB'(1));

endmodule

// File: rtl/frame_gen_sequencer.sv
// Block-type sequencer for the PRBS frame generator.
// Optional error injection: define FRAME_GEN_ERR_INJ_EN.
module frame_gen_sequencer
  import frame_gen_pkg::*;
#(
  parameter int NB_LEN  = 16,
  parameter int NB_GAP  = 8,
  parameter int NB_FCNT = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_run,
  input  logic [NB_LEN-1:0]  i_frame_len,
  input  logic [NB_GAP-1:0]  i_gap_len,
`ifdef FRAME_GEN_ERR_INJ_EN
  input  logic               i_err_inject,
`endif
  output logic               o_data_enable,
  output logic [NB_TYPE-1:0] o_block_type,
  output logic               o_valid,
  output logic               o_busy,
  output logic [NB_FCNT-1:0] o_frame_count
);

  state_t            state;
  logic              data_tc;
  logic              gap_tc;
  logic [NB_GAP-1:0] gap_val;

  assign gap_val = (i_gap_len == '0) ? NB_GAP'(1) : i_gap_len;

  frame_gen_len_counter #(
    .NB      (NB_LEN),
    .RST_LIM ('0)
  ) u_data_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (i_enable && state == S_START),
    .i_limit (i_frame_len),
    .i_inc   (i_enable && state == S_DATA),
    .o_tc    (data_tc)
  );

  // Gap limit comes out of reset at 1 so the first START follows one IDLE.
  frame_gen_len_counter #(
    .NB      (NB_GAP),
    .RST_LIM (NB_GAP'(1))
  ) u_gap_cnt (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (i_enable && state == S_TERM),
    .i_limit (gap_val),
    .i_inc   (i_enable && state == S_IDLE),
    .o_tc    (gap_tc)
  );

`ifdef FRAME_GEN_ERR_INJ_EN
  logic armed;
  logic err_use;

  assign err_use = armed && i_enable && state == S_DATA;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      armed <= 1'b0;
    end else if (err_use) begin
      armed <= 1'b0;
    end else if (i_err_inject) begin
      armed <= 1'b1;
    end
  end
`else
  localparam logic armed = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= S_IDLE;
      o_block_type  <= BT_IDLE;
      o_data_enable <= 1'b0;
      o_valid       <= 1'b0;
      o_busy        <= 1'b0;
      o_frame_count <= '0;
    end else if (!i_enable) begin
      o_data_enable <= 1'b0;
      o_valid       <= 1'b0;
    end else begin
      o_valid       <= 1'b1;
      o_data_enable <= 1'b0;
      unique case (state)
        S_IDLE: begin
          o_block_type <= BT_IDLE;
          o_busy       <= 1'b0;
          if (gap_tc && i_run) state <= S_START;
        end
        S_START: begin
          o_block_type <= BT_START;
          o_busy       <= 1'b1;
          state        <= (i_frame_len == '0) ? S_TERM : S_DATA;
        end
        S_DATA: begin
          o_block_type  <= armed ? BT_ERROR : BT_DATA;
          o_busy        <= 1'b1;
          o_data_enable <= 1'b1;
          if (data_tc) state <= S_TERM;
        end
        S_TERM: begin
          o_block_type  <= BT_TERM;
          o_busy        <= 1'b1;
          o_frame_count <= o_frame_count + NB_FCNT'(1);
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_gen_sequencer.sv
// Directed vector bench for frame_gen_sequencer.
// Covers FRAME_GEN_ERR_INJ_EN when the macro is defined.
module tb_frame_gen_sequencer;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] S = 3'd1;
  localparam logic [2:0] D = 3'd2;
  localparam logic [2:0] T = 3'd3;
  localparam logic [2:0] E = 3'd4;

  typedef struct {
    logic        rst;
    logic        en;
    logic        run;
    logic        err;
    logic [15:0] flen;
    logic [7:0]  glen;
    logic [2:0]  typ;
    logic        de;
    logic        val;
    logic        busy;
    logic [31:0] fcnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        run;
  logic        err;
  logic [15:0] flen;
  logic [7:0]  glen;
  logic        de;
  logic [2:0]  typ;
  logic        val;
  logic        busy;
  logic [31:0] fcnt;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  frame_gen_sequencer dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_enable      (en),
    .i_run         (run),
    .i_frame_len   (flen),
    .i_gap_len     (glen),
`ifdef FRAME_GEN_ERR_INJ_EN
    .i_err_inject  (err),
`endif
    .o_data_enable (de),
    .o_block_type  (typ),
    .o_valid       (val),
    .o_busy        (busy),
    .o_frame_count (fcnt)
  );

  task automatic v(input logic r, input logic e, input logic rn,
                   input logic er, input logic [15:0] fl,
                   input logic [7:0] gl, input logic [2:0] ty,
                   input logic d, input logic va, input logic b,
                   input logic [31:0] fc);
    vec_t x;
    x.rst = r; x.en = e; x.run = rn; x.err = er;
    x.flen = fl; x.glen = gl;
    x.typ = ty; x.de = d; x.val = va; x.busy = b; x.fcnt = fc;
    vecs.push_back(x);
  endtask

  task automatic rep(input int k, input logic e, input logic rn,
                     input logic [15:0] fl, input logic [7:0] gl,
                     input logic [2:0] ty, input logic d,
                     input logic va, input logic b,
                     input logic [31:0] fc);
    for (int i = 0; i < k; i++) v(0, e, rn, 0, fl, gl, ty, d, va, b, fc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t x);
    rst = x.rst; en = x.en; run = x.run; err = x.err;
    flen = x.flen; glen = x.glen;
    tick();
    n_vec++;
    if (typ !== x.typ || de !== x.de || val !== x.val ||
        busy !== x.busy || fcnt !== x.fcnt) begin
      n_bad++;
      $display("FAIL vec%0d: type/de/valid/busy/fcnt got %0d/%b/%b/%b/%0d expected %0d/%b/%b/%b/%0d",
               idx, typ, de, val, busy, fcnt,
               x.typ, x.de, x.val, x.busy, x.fcnt);
    end
  endtask

  initial begin
    int  dcnt;
    bit  seen;
    rst = 1'b1; en = 1'b1; run = 1'b0; err = 1'b0;
    flen = '0; glen = '0;

    // basic frame: len 4, gap 2
    v(1, 1, 0, 0, 4, 2, I, 0, 0, 0, 0);
    v(1, 1, 0, 0, 4, 2, I, 0, 0, 0, 0);
    v(0, 1, 1, 0, 4, 2, I, 0, 1, 0, 0);
    v(0, 1, 1, 0, 4, 2, S, 0, 1, 1, 0);
    rep(4, 1, 1, 4, 2, D, 1, 1, 1, 0);
    v(0, 1, 1, 0, 4, 2, T, 0, 1, 1, 1);
    rep(2, 1, 1, 4, 2, I, 0, 1, 0, 1);
    v(0, 1, 1, 0, 4, 2, S, 0, 1, 1, 1);
    v(0, 1, 1, 0, 4, 2, D, 1, 1, 1, 1);

    // zero length, zero gap
    v(1, 1, 0, 0, 0, 0, I, 0, 0, 0, 0);
    v(0, 1, 1, 0, 0, 0, I, 0, 1, 0, 0);
    v(0, 1, 1, 0, 0, 0, S, 0, 1, 1, 0);
    v(0, 1, 1, 0, 0, 0, T, 0, 1, 1, 1);
    v(0, 1, 1, 0, 0, 0, I, 0, 1, 0, 1);
    v(0, 1, 1, 0, 0, 0, S, 0, 1, 1, 1);
    v(0, 1, 1, 0, 0, 0, T, 0, 1, 1, 2);
    v(0, 1, 1, 0, 0, 0, I, 0, 1, 0, 2);
    v(0, 1, 1, 0, 0, 0, S, 0, 1, 1, 2);

    // stall for 5 cycles after the 3rd DATA
    v(1, 1, 0, 0, 8, 1, I, 0, 0, 0, 0);
    v(0, 1, 1, 0, 8, 1, I, 0, 1, 0, 0);
    v(0, 1, 1, 0, 8, 1, S, 0, 1, 1, 0);
    rep(3, 1, 1, 8, 1, D, 1, 1, 1, 0);
    rep(5, 0, 1, 8, 1, D, 0, 0, 1, 0);
    rep(5, 1, 1, 8, 1, D, 1, 1, 1, 0);
    v(0, 1, 1, 0, 8, 1, T, 0, 1, 1, 1);
    v(0, 1, 1, 0, 8, 1, I, 0, 1, 0, 1);

    // run dropped at 2nd DATA of a 10-block frame
    v(1, 1, 0, 0, 10, 1, I, 0, 0, 0, 0);
    v(0, 1, 1, 0, 10, 1, I, 0, 1, 0, 0);
    v(0, 1, 1, 0, 10, 1, S, 0, 1, 1, 0);
    rep(2, 1, 1, 10, 1, D, 1, 1, 1, 0);
    rep(8, 1, 0, 10, 1, D, 1, 1, 1, 0);
    v(0, 1, 0, 0, 10, 1, T, 0, 1, 1, 1);
    rep(4, 1, 0, 10, 1, I, 0, 1, 0, 1);

    // reset during DATA 3 of 6
    v(0, 1, 1, 0, 6, 1, I, 0, 1, 0, 1);
    v(0, 1, 1, 0, 6, 1, S, 0, 1, 1, 1);
    rep(3, 1, 1, 6, 1, D, 1, 1, 1, 1);
    v(1, 1, 1, 0, 6, 1, I, 0, 0, 0, 0);
    rep(3, 1, 0, 6, 1, I, 0, 1, 0, 0);

`ifdef FRAME_GEN_ERR_INJ_EN
    // error pulse during IDLE tags the first DATA
    v(1, 1, 0, 0, 3, 1, I, 0, 0, 0, 0);
    v(0, 1, 1, 1, 3, 1, I, 0, 1, 0, 0);
    v(0, 1, 1, 0, 3, 1, S, 0, 1, 1, 0);
    v(0, 1, 1, 0, 3, 1, E, 1, 1, 1, 0);
    rep(2, 1, 1, 3, 1, D, 1, 1, 1, 0);
    v(0, 1, 0, 0, 3, 1, T, 0, 1, 1, 1);
    v(0, 1, 0, 0, 3, 1, I, 0, 1, 0, 1);
`endif

    foreach (vecs[i]) apply(i, vecs[i]);

    // maximum frame length
    rst = 1'b1; en = 1'b1; run = 1'b0; err = 1'b0;
    flen = 16'hFFFF; glen = 8'd1;
    tick();
    rst = 1'b0; run = 1'b1;
    dcnt = 0;
    seen = 1'b0;
    for (int c = 0; c < 70000 && !seen; c++) begin
      tick();
      if (de) dcnt++;
      if (typ == T) seen = 1'b1;
    end
    check("max_term_seen", 64'(seen), 64'd1);
    check("max_data_slots", 64'(dcnt), 64'd65535);
    check("max_fcnt", 64'(fcnt), 64'd1);
    run = 1'b0;
    tick();
    check("max_after_idle", 64'({typ, busy}), 64'({I, 1'b0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_gen_sequencer.md
Name: frame_gen_sequencer

Overview:
- Controller for the frame generator's 64-bit PRBS data block source.
- Decides, block by block, whether the current 64-bit slot carries IDLE, START, DATA or TERM.
- Gates the data source's enable so its PRBS lanes advance only on DATA slots.
- Feeds the downstream block-encoder stage of the PCS test datapath with a block-type tag per slot.

Parameters:
- NB_LEN, 16, width of frame-length config and data-block counter.
- NB_GAP, 8, width of inter-frame idle-gap config and idle counter.
- NB_FCNT, 32, width of the transmitted-frame counter.
- NB_TYPE, 3, width of the block-type tag.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  global clock enable; low = full stall.
- i_run  in  1  level; high = keep emitting frames.
- i_frame_len  in  NB_LEN  DATA blocks per frame; sampled on the START slot.
- i_gap_len  in  NB_GAP  IDLE blocks between frames; sampled on TERM.
- o_data_enable  out  1  enable to the data source; high only on DATA slots while i_enable is high.
- o_block_type  out  NB_TYPE  0=IDLE, 1=START, 2=DATA, 3=TERM, 4=ERROR.
- o_valid  out  1  high on every slot where i_enable is high.
- o_busy  out  1  high from START through TERM inclusive.
- o_frame_count  out  NB_FCNT  completed frames (TERM slots emitted).

Behaviour:
- All outputs are registered; 1-cycle latency from state to outputs.
- Reset values: o_block_type=IDLE, all other outputs 0, state=S_IDLE, counters 0.
- When i_enable=0:
  - state, counters and outputs hold;
  - o_data_enable and o_valid are forced to 0.
- FSM, one transition per enabled cycle:
  - S_IDLE: emit IDLE. Stay while gap_cnt < gap_lat, or while i_run=0. Else go to S_START.
  - S_START: emit START; latch len_lat=i_frame_len; clear data_cnt. If len_lat=0, go to S_TERM, else S_DATA.
  - S_DATA: emit DATA; o_data_enable=1; data_cnt++. When data_cnt reaches len_lat-1, go to S_TERM.
  - S_TERM: emit TERM; o_frame_count++ (wraps modulo 2^NB_FCNT); latch gap_lat=max(i_gap_len,1); clear gap_cnt; go to S_IDLE.
- Minimum inter-frame gap is 1 IDLE block. i_gap_len=0 is treated as 1.
- i_run deasserted mid-frame: the current frame completes through TERM, then the FSM holds in S_IDLE.
- i_run asserted out of reset: first START appears after 1 IDLE slot (gap_lat resets to 1).
- Config changes mid-frame are ignored until the next sampling point.
- Maximum frame length: i_frame_len=2^NB_LEN-1 gives exactly that many DATA slots with no counter overflow.
- i_reset in any state: next cycle is S_IDLE with reset outputs. A partial frame is abandoned and no TERM is issued.
- o_busy is high while the registered block type is START, DATA or TERM.

Optional Feature:
- Macro: FRAME_GEN_ERR_INJ_EN.
- Defined:
  - adds input i_err_inject (1 bit, pulse).
  - A pulse arms a sticky flag. The next DATA slot is tagged ERROR (4) instead of DATA, with o_data_enable still 1 so the PRBS sequence stays aligned.
  - The flag clears after use.
  - A pulse arriving while armed is absorbed; one error per arm.
  - Reset clears the flag.
- Undefined: no port; type 4 is never emitted.

Decomposition:
- Shared package frame_gen_pkg holds:
  - block-type localparams (IDLE/START/DATA/TERM/ERROR);
  - FSM state encodings;
  - NB_TYPE.
- Natural sub-module: frame_gen_len_counter, a loadable up-counter with terminal-count flag, instanced twice (data and gap counters).
- Top level holds the FSM and output registers.

Test Plan:
- Basic frame: reset, i_run=1, frame_len=4, gap_len=2, i_enable=1.
  - Response: IDLE, START, DATA×4, TERM, IDLE×2, START…
  - o_data_enable high on exactly 4 cycles per frame; o_frame_count=1 after the first TERM.
- Zero-length and zero-gap: frame_len=0, gap_len=0.
  - Response: repeating START, TERM, IDLE pattern (3-slot period); o_data_enable never high.
- Stall: frame_len=8; drop i_enable for 5 cycles during the 3rd DATA slot.
  - Response: o_valid=0 and o_data_enable=0 during the stall; resumes at the 4th DATA; the frame still totals 8 DATA slots.
- Stop mid-frame: frame_len=10; deassert i_run at the 2nd DATA slot.
  - Response: all 10 DATA slots and TERM are emitted, then IDLE indefinitely with o_busy=0.
- Reset mid-frame: assert i_reset during DATA slot 3 of 6.
  - Response: next cycle shows IDLE and o_frame_count=0; no TERM appears.
- FRAME_GEN_ERR_INJ_EN: pulse i_err_inject during IDLE with frame_len=3.
  - Response: START, ERROR, DATA, DATA, TERM; o_data_enable high on 3 slots.
